// File: rtl/cpu_program_loader.sv
// -----------------------------------------------------------------------------
// cpu_program_loader
//
// Streams a program image from a byte-wide host link into the CPU word memory
// and keeps the CPU held in reset until the whole image has been written and
// its checksum has matched.
//
// Image format (byte stream):
//   LEN_HI, LEN_LO            big-endian word count N
//   N words                   BYTES_PER_WORD bytes each, MSB first
//   CHK                       XOR of all data bytes (header not included)
//
// Handshake: a byte moves on every rising edge where in_valid and in_ready are
// both 1. in_ready is a registered function of the FSM state only; it never
// looks at in_valid. The host may hold in_valid low for any number of cycles
// and the loader simply waits.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-low reset
//   start         one-cycle pulse, begins or restarts a load (beats a handshake)
//   in_data       stream byte
//   in_valid      in_data is valid
//   in_ready      loader accepts a byte this cycle
//   mem_we        one-cycle memory write strobe
//   mem_addr      word address for the write
//   mem_wdata     assembled word for the write
//   cpu_hold      1 keeps the CPU in reset
//   done          image loaded and checksum matched
//   error         load failed (oversize header or checksum mismatch)
//   words_loaded  words written during the current load
//   dbg_state     current FSM state encoding (see state_t)
// -----------------------------------------------------------------------------
module cpu_program_loader #(
  parameter int WORD_WIDTH     = 16,                   // multiple of 8, 8..64
  parameter int MEMORY_SIZE    = 32,
  parameter int ADDR_WIDTH     = $clog2(MEMORY_SIZE),
  parameter int BYTES_PER_WORD = WORD_WIDTH / 8        // derived, leave as is
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded,
  output logic [2:0]            dbg_state
);

  // S_WRITE is the single cycle in which mem_we is high.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);

  state_t                state;
  logic [15:0]           len;        // word count N from the header
  logic [7:0]            chk;        // running XOR of data bytes
  logic [WORD_WIDTH-1:0] word_reg;   // word being assembled
  logic [BCW-1:0]        byte_cnt;   // byte position inside the current word

  logic                  hs;
  logic [15:0]           len_next;
  logic [WORD_WIDTH-1:0] word_next;

  assign hs        = in_valid & in_ready;
  assign len_next  = {len[15:8], in_data};
  // Shift-in form keeps WORD_WIDTH == 8 legal (no zero-width slice).
  assign word_next = (word_reg << 8) | WORD_WIDTH'(in_data);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      chk          <= '0;
      word_reg     <= '0;
      byte_cnt     <= '0;
    end else if (start) begin
      // Restart from any state; a byte offered on this edge is dropped.
      state        <= S_HDR_HI;
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      chk          <= '0;
      word_reg     <= '0;
      byte_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b0;
        end

        S_HDR_HI: begin
          if (hs) begin
            len[15:8] <= in_data;
            state     <= S_HDR_LO;
          end
        end

        S_HDR_LO: begin
          if (hs) begin
            len[7:0] <= in_data;
            if (int'(len_next) > MEMORY_SIZE) begin
              // Oversize image: stop before any data byte is taken.
              state    <= S_ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end else if (len_next == 16'd0) begin
              state <= S_CHECK;
            end else begin
              state    <= S_DATA;
              byte_cnt <= '0;
            end
          end
        end

        S_DATA: begin
          if (hs) begin
            word_reg <= word_next;
            chk      <= chk ^ in_data;
            if (byte_cnt == LAST_BYTE) begin
              // Word complete: write it on the very next cycle.
              byte_cnt  <= '0;
              mem_we    <= 1'b1;
              mem_wdata <= word_next;
              in_ready  <= 1'b0;
              state     <= S_WRITE;
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end

        S_WRITE: begin
          mem_we       <= 1'b0;
          in_ready     <= 1'b1;
          words_loaded <= words_loaded + 16'd1;
          if (words_loaded + 16'd1 == len) begin
            // Last word: leave mem_addr on it so N == MEMORY_SIZE never wraps.
            state <= S_CHECK;
          end else begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            state    <= S_DATA;
          end
        end

        S_CHECK: begin
          if (hs) begin
            in_ready <= 1'b0;
            if (in_data == chk) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= S_ERROR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end

        S_DONE: begin
          in_ready <= 1'b0;
        end

        S_ERROR: begin
          in_ready <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// -----------------------------------------------------------------------------
// tb_cpu_program_loader
//
// Two loader instances share clk/rst/in_data/in_valid: dut_a uses the default
// 16-bit x 32-word configuration, dut_b is 32-bit x 4 words. "sel" picks which
// one the driver and the write monitor talk to; each has its own start.
// Expected writes are pushed by the driver (decoded from the image it sends)
// and popped by the monitor when mem_we is seen.
// -----------------------------------------------------------------------------
module tb_cpu_program_loader;

  localparam int SB_W = 48;  // {addr[15:0], data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        sel = 1'b0;

  logic        in_ready_a, mem_we_a, cpu_hold_a, done_a, error_a;
  logic [4:0]  mem_addr_a;
  logic [15:0] mem_wdata_a, words_loaded_a;
  logic [2:0]  dbg_state_a;

  logic        in_ready_b, mem_we_b, cpu_hold_b, done_b, error_b;
  logic [1:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [15:0] words_loaded_b;
  logic [2:0]  dbg_state_b;

  cpu_program_loader dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .cpu_hold(cpu_hold_a), .done(done_a), .error(error_a),
    .words_loaded(words_loaded_a), .dbg_state(dbg_state_a)
  );

  cpu_program_loader #(.WORD_WIDTH(32), .MEMORY_SIZE(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b),
    .words_loaded(words_loaded_b), .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard state ----------------
  int compared = 0;
  int mismatched = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [7:0] img_q[$];
  int last_hs = -10;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic cur_rdy();
    return sel ? in_ready_b : in_ready_a;
  endfunction

  // ---------------- monitor ----------------
  logic [SB_W-1:0] act_w;
  always @(negedge clk) begin
    if (rst) begin
      if (sel ? mem_we_b : mem_we_a) begin
        act_w = sel ? {16'(mem_addr_b), mem_wdata_b} : {16'(mem_addr_a), 32'(mem_wdata_a)};
        if (exp_q.size() == 0) begin
          check("unexpected_write", act_w, '0);
        end else begin
          check("write_addr_data", act_w, exp_q.pop_front());
        end
        check("write_latency", cyc, last_hs);
        check("write_ready_low", cur_rdy(), 1'b0);
      end
      if (sel ? mem_we_a : mem_we_b) check("stray_write_other_dut", 1'b1, 1'b0);
      if (done_a && error_a) check("done_error_a_exclusive", 1'b1, 1'b0);
      if (done_b && error_b) check("done_error_b_exclusive", 1'b1, 1'b0);
      // A handshake seen now completes on the next rising edge.
      if (in_valid && cur_rdy()) last_hs = cyc + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) step();
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!cur_rdy() && n < 50) begin
      step();
      n++;
    end
    if (!cur_rdy()) begin
      check("send_byte_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
    end else begin
      step();
      in_valid = 1'b0;
    end
  endtask

  // Sends img_q; decodes the header itself and queues each expected write
  // before the final byte of that word goes out. gap < 0 means random 0..1.
  task automatic send_stream(input int gap);
    int bpw, mem, n, g;
    logic [31:0] w;
    bpw = sel ? 4 : 2;
    mem = sel ? 4 : 32;
    n = 0;
    w = '0;
    for (int i = 0; i < img_q.size(); i++) begin
      if (i == 1) n = int'({img_q[0], img_q[1]});
      if (i >= 2 && n <= mem && i < 2 + n * bpw) begin
        w = (w << 8) | 32'(img_q[i]);
        if ((i - 2) % bpw == bpw - 1) begin
          exp_q.push_back({16'((i - 2) / bpw), w});
          w = '0;
        end
      end
      g = (gap < 0) ? int'($urandom_range(0, 1)) : gap;
      send_byte(img_q[i], g);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_in_ready"}, in_ready_a, 1'b0);
    check({tag, "_mem_we"}, mem_we_a, 1'b0);
    check({tag, "_mem_addr"}, mem_addr_a, 5'd0);
    check({tag, "_mem_wdata"}, mem_wdata_a, 16'd0);
    check({tag, "_cpu_hold"}, cpu_hold_a, 1'b1);
    check({tag, "_done"}, done_a, 1'b0);
    check({tag, "_error"}, error_a, 1'b0);
    check({tag, "_words"}, words_loaded_a, 16'd0);
    check({tag, "_state_idle"}, dbg_state_a, 3'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [79:0] img;       // bytes left-aligned, first byte in [79:72]
    int          nbytes;
    logic        exp_done;
    logic        exp_err;
    int          exp_words;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Nominal: 12^34^AB^CD^00^01 = 0x41.
    vecs[0] = '{{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h41, 8'h00}, 9, 1'b1, 1'b0, 3};
    vecs[1] = '{{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h44, 8'h00}, 9, 1'b0, 1'b1, 3};
    vecs[2] = '{{8'h00, 8'h21, 64'h0}, 2, 1'b0, 1'b1, 0};                // 33 > 32
    vecs[3] = '{{8'h00, 8'h00, 8'h00, 56'h0}, 3, 1'b1, 1'b0, 0};         // empty, good
    vecs[4] = '{{8'h00, 8'h00, 8'h01, 56'h0}, 3, 1'b0, 1'b1, 0};         // empty, bad
    vecs[5] = '{{8'h01, 8'h00, 64'h0}, 2, 1'b0, 1'b1, 0};                // 256 > 32
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic [7:0] x;
    rst = 1'b0;
    repeat (3) step();
    check_reset_a("reset");
    check("reset_b_hold", cpu_hold_b, 1'b1);
    rst = 1'b1;
    step();

    // Table-driven images on the default configuration.
    sel = 1'b0;
    for (int v = 0; v < 6; v++) begin
      pulse_start();
      check($sformatf("v%0d_ready_after_start", v), in_ready_a, 1'b1);
      check($sformatf("v%0d_hold_after_start", v), cpu_hold_a, 1'b1);
      img_q.delete();
      for (int i = 0; i < vecs[v].nbytes; i++) img_q.push_back(vecs[v].img[79 - 8 * i -: 8]);
      send_stream(0);
      // Outcome is registered on the edge that took the last byte.
      check($sformatf("v%0d_done", v), done_a, vecs[v].exp_done);
      check($sformatf("v%0d_error", v), error_a, vecs[v].exp_err);
      check($sformatf("v%0d_cpu_hold", v), cpu_hold_a, !vecs[v].exp_done);
      check($sformatf("v%0d_words", v), words_loaded_a, 16'(vecs[v].exp_words));
      check($sformatf("v%0d_ready_low", v), in_ready_a, 1'b0);
      in_valid = 1'b1;  // offered bytes must be ignored in DONE/ERROR
      repeat (4) step();
      in_valid = 1'b0;
      check($sformatf("v%0d_ready_still_low", v), in_ready_a, 1'b0);
      check($sformatf("v%0d_done_stable", v), done_a, vecs[v].exp_done);
      check($sformatf("v%0d_queue_empty", v), exp_q.size(), 0);
    end

    // Full depth on the default configuration, random data and gaps.
    pulse_start();
    img_q.delete();
    img_q.push_back(8'h00);
    img_q.push_back(8'h20);
    x = 8'h00;
    for (int i = 0; i < 64; i++) begin
      img_q.push_back(8'($urandom_range(0, 255)));
      x = x ^ img_q[img_q.size() - 1];
    end
    img_q.push_back(x);
    send_stream(-1);
    check("full_a_done", done_a, 1'b1);
    check("full_a_words", words_loaded_a, 16'd32);
    check("full_a_addr_no_wrap", mem_addr_a, 5'd31);
    check("full_a_queue_empty", exp_q.size(), 0);

    // Restart during word 2: the byte offered with start is dropped.
    pulse_start();
    img_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB};
    send_stream(0);
    in_data  = 8'hCD;
    in_valid = 1'b1;
    start_a  = 1'b1;
    step();
    start_a  = 1'b0;
    in_valid = 1'b0;
    check("restart_cpu_hold", cpu_hold_a, 1'b1);
    check("restart_words", words_loaded_a, 16'd0);
    check("restart_state_hdr_hi", dbg_state_a, 3'd1);
    check("restart_ready", in_ready_a, 1'b1);
    img_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h41};
    send_stream(0);
    check("restart_reload_done", done_a, 1'b1);
    check("restart_reload_words", words_loaded_a, 16'd3);
    check("restart_queue_empty", exp_q.size(), 0);

    // Reset during DATA: outputs return to reset values on that edge.
    pulse_start();
    img_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB};
    send_stream(0);
    in_data  = 8'hCD;
    in_valid = 1'b1;
    rst      = 1'b0;
    step();
    check_reset_a("midreset");
    rst = 1'b1;
    repeat (5) step();  // in_valid still high: IDLE must not take it
    in_valid = 1'b0;
    check_reset_a("after_midreset");
    check("midreset_queue_empty", exp_q.size(), 0);

    // 32-bit x 4 words, full depth, in_valid toggled every other cycle.
    sel = 1'b1;
    pulse_start();
    img_q.delete();
    img_q.push_back(8'h00);
    img_q.push_back(8'h04);
    x = 8'h00;
    for (int i = 0; i < 16; i++) begin
      img_q.push_back(8'($urandom_range(0, 255)));
      x = x ^ img_q[img_q.size() - 1];
    end
    img_q.push_back(x);
    send_stream(1);
    check("b_done", done_b, 1'b1);
    check("b_error", error_b, 1'b0);
    check("b_cpu_hold", cpu_hold_b, 1'b0);
    check("b_words", words_loaded_b, 16'd4);
    check("b_addr_no_wrap", mem_addr_b, 2'd3);
    repeat (3) step();
    check("b_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
